// File: rtl/mult_div_unit_if.sv
// Start/busy request bus and HI/LO write-port bundle for mult_div_unit.
// The master side issues requests; the slave side is the unit itself.
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        HI_write_enable;
   logic        LO_write_enable;
   logic [31:0] HI_write_data;
   logic [31:0] LO_write_data;

   modport master (
      output start, op, operand_a, operand_b,
      input  busy, HI_write_enable, LO_write_enable, HI_write_data, LO_write_data
   );

   modport slave (
      input  start, op, operand_a, operand_b,
      output busy, HI_write_enable, LO_write_enable, HI_write_data, LO_write_data
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO.
// Optional divider datapath is compiled in when MULT_DIV_DIVIDE_EN is defined.
module mult_div_unit #(
   parameter int unsigned ITER_CYCLES = 32
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(ITER_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;
   typedef enum logic [2:0] {
      OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
      OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5
   } op_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [63:0]      acc_q, acc_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic             signed_op;
   logic [32:0]      mul_sum;
   logic [63:0]      mul_prod;

   assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
   assign mul_prod  = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;

`ifdef MULT_DIV_DIVIDE_EN
   logic [32:0] rem_q, rem_d;
   logic        is_div;
   logic [33:0] div_sh;
   logic [33:0] div_diff;
   logic [31:0] div_quo;
   logic [31:0] div_rem;

   assign is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
   assign div_sh   = {rem_q, a_q[31]};
   assign div_diff = div_sh - {2'b00, b_q};
   // A zero divisor naturally leaves |a| in the remainder; only the quotient needs forcing.
   assign div_quo  = (b_q == 32'd0) ? '1 : ((sa_q ^ sb_q) ? (~a_q + 32'd1) : a_q);
   assign div_rem  = sa_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_MULT, OP_MULTU: state_d = ITER;
`ifdef MULT_DIV_DIVIDE_EN
                  OP_DIV, OP_DIVU:   state_d = ITER;
`else
                  OP_DIV, OP_DIVU:   state_d = DONE;
`endif
                  OP_MTHI, OP_MTLO:  state_d = DONE;
                  default:           state_d = IDLE;
               endcase
            end
         end
         ITER:    if (cnt_q == CNT_LAST) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy            = (state_q != IDLE);
      bus.HI_write_enable = 1'b0;
      bus.LO_write_enable = 1'b0;
      if (state_q == DONE) begin
         bus.HI_write_enable = (op_q != OP_MTLO);
         bus.LO_write_enable = (op_q != OP_MTHI);
      end
   end

   assign bus.HI_write_data = hi_q;
   assign bus.LO_write_data = lo_q;

   always_comb begin
      cnt_d = cnt_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      acc_d = acc_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
`ifdef MULT_DIV_DIVIDE_EN
      rem_d = rem_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start && (bus.op <= OP_DIVU)) begin
               op_d  = bus.op;
               sa_d  = signed_op & bus.operand_a[31];
               sb_d  = signed_op & bus.operand_b[31];
               a_d   = (signed_op && bus.operand_a[31]) ? (~bus.operand_a + 32'd1) : bus.operand_a;
               b_d   = (signed_op && bus.operand_b[31]) ? (~bus.operand_b + 32'd1) : bus.operand_b;
               acc_d = '0;
               cnt_d = '0;
`ifdef MULT_DIV_DIVIDE_EN
               rem_d = '0;
`else
               if (bus.op >= OP_DIV) begin
                  hi_d = '0;
                  lo_d = '0;
               end
`endif
            end else if (bus.start && (bus.op == OP_MTHI)) begin
               op_d = bus.op;
               hi_d = bus.operand_a;
            end else if (bus.start && (bus.op == OP_MTLO)) begin
               op_d = bus.op;
               lo_d = bus.operand_a;
            end
         end
         ITER: begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef MULT_DIV_DIVIDE_EN
            if (is_div) begin
               // a_q shifts dividend bits out the top and quotient bits in at the bottom.
               if (!div_diff[33]) begin
                  rem_d = div_diff[32:0];
                  a_d   = {a_q[30:0], 1'b1};
               end else begin
                  rem_d = div_sh[32:0];
                  a_d   = {a_q[30:0], 1'b0};
               end
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
               b_d   = {1'b0, b_q[31:1]};
            end
`else
            acc_d = {mul_sum, acc_q[31:1]};
            b_d   = {1'b0, b_q[31:1]};
`endif
         end
         FIX: begin
`ifdef MULT_DIV_DIVIDE_EN
            if (is_div) begin
               hi_d = div_rem;
               lo_d = div_quo;
            end else begin
               hi_d = mul_prod[63:32];
               lo_d = mul_prod[31:0];
            end
`else
            hi_d = mul_prod[63:32];
            lo_d = mul_prod[31:0];
`endif
         end
         DONE:    ;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         acc_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
`ifdef MULT_DIV_DIVIDE_EN
         rem_q <= '0;
`endif
      end else begin
         cnt_q <= cnt_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
         acc_q <= acc_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
`ifdef MULT_DIV_DIVIDE_EN
         rem_q <= rem_d;
`endif
      end
   end
endmodule
